// File: rtl/irq_pending_latch.sv
// irq_pending_latch: four-channel interrupt capture stage feeding the
// 4:2 priority encoder with registered, level-held, maskable requests.
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq_in,
    input  logic       mask_we,
    input  logic [3:0] mask_in,
    input  logic       ack,
    input  logic [1:0] ack_idx,
    input  logic       ovf_clr,
    output logic [3:0] pend,
    output logic [3:0] raw_pend,
    output logic [3:0] mask,
    output logic [3:0] ovf,
    output logic       any_pend
);

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [SYNC_STAGES-1:0][3:0] sync_d;
    logic [3:0] prev_q;
    logic [3:0] prev_d;
    logic [3:0] raw_pend_q;
    logic [3:0] raw_pend_d;
    logic [3:0] pend_q;
    logic [3:0] pend_d;
    logic [3:0] mask_q;
    logic [3:0] mask_d;
    logic [3:0] ovf_q;
    logic [3:0] ovf_d;
    logic       any_pend_q;
    logic       any_pend_d;

    logic [3:0] sync_out;
    logic [3:0] evt;
    logic [3:0] ack_vec;

    // One-hot view of the acknowledge so it only ever touches one bit.
    always_comb begin
        ack_vec = 4'b0000;
        if (ack) begin
            ack_vec[ack_idx] = 1'b1;
        end
    end

    // Synchroniser shift, edge detect and next-state for all registers.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], irq_in};
        sync_out = sync_q[SYNC_STAGES-1];
        prev_d   = sync_out;
        evt      = sync_out & ~prev_q;

        // A new event beats an ack to the same bit so nothing is lost.
        raw_pend_d = evt | (raw_pend_q & ~ack_vec);

        // Overflow: event lands on a bit still pending and not being acked.
        ovf_d = (ovf_clr ? 4'b0000 : ovf_q)
              | (evt & raw_pend_q & ~ack_vec);

        mask_d = mask_we ? mask_in : mask_q;

        // Masked view is registered so the encoder sees glitch-free input.
        pend_d     = raw_pend_q & ~mask_q;
        any_pend_d = |pend_d;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= 4'b0000;
            raw_pend_q <= 4'b0000;
            pend_q     <= 4'b0000;
            mask_q     <= 4'b0000;
            ovf_q      <= 4'b0000;
            any_pend_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            raw_pend_q <= raw_pend_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            ovf_q      <= ovf_d;
            any_pend_q <= any_pend_d;
        end
    end

    assign pend     = pend_q;
    assign raw_pend = raw_pend_q;
    assign mask     = mask_q;
    assign ovf      = ovf_q;
    assign any_pend = any_pend_q;

endmodule
